// File: rtl/hdlc_rx_channel.sv
// HDLC receive front end: flag/abort detection, zero removal, LSB-first byte assembly and framing.
// Defining HDLC_RX_FCS_CHECK_EN adds a CRC-16 (x^16+x^15+x^2+1) residue check at end of frame.
module hdlc_rx_channel #(
  parameter int unsigned MAX_FRAME_BYTES = 128,
  parameter int unsigned MIN_FRAME_BYTES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  input  logic       Rx_FCSen,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_WrBuff,
  output logic       Rx_EoF,
  output logic       Rx_AbortSignal,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic       Rx_FCSerr,
  output logic [7:0] Rx_ByteCount
);
  localparam logic [7:0] MAX_B = 8'(MAX_FRAME_BYTES);
  localparam logic [7:0] MIN_B = 8'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, START, DATA} state_t;
  state_t state, state_next;

  logic [7:0] win;
  logic [7:0] fmask;
  logic [2:0] ones;
  logic [2:0] bit_cnt;
  logic       flag_match, abort_match, exit_bit, exit_flag, stuffed, kept;
  logic       frame_start, frame_end, frame_abort, byte_done, fcs_bad;

  assign flag_match  = (win == 8'b0111_1110);
  assign abort_match = (win == 8'b1111_1110);
  assign exit_bit    = win[0];
  // fmask tracks which window positions belong to a matched flag/abort so those bits never reach data
  assign exit_flag   = flag_match | abort_match | fmask[0];
  assign stuffed     = (ones >= 3'd5) && !exit_bit;
  assign kept        = RxEN && (state != IDLE) && !exit_flag && !stuffed;
  assign byte_done   = kept && !frame_start && (bit_cnt == 3'd7) && !frame_end && !frame_abort;
  assign Rx_ValidFrame = (state == DATA);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    frame_abort = 1'b0;
    if (!RxEN) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (Rx_FlagDetect) state_next = START;
        START: begin
          if (Rx_AbortDetect) state_next = IDLE;
          else if (kept) begin
            state_next  = DATA;
            frame_start = 1'b1;
          end
        end
        DATA: begin
          if (Rx_AbortDetect) begin
            state_next  = IDLE;
            frame_abort = 1'b1;
          end else if (Rx_FlagDetect) begin
            state_next = START;
            frame_end  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef HDLC_RX_FCS_CHECK_EN
  logic [15:0] crc, crc_in;
  logic        crc_fb;
  assign crc_in  = frame_start ? '0 : crc;
  assign crc_fb  = exit_bit ^ crc_in[15];
  assign fcs_bad = Rx_FCSen && (crc != '0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      crc <= '0;
    else if (kept) crc <= {crc_in[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
  end
`else
  logic unused_fcsen;
  assign unused_fcsen = Rx_FCSen;
  assign fcs_bad      = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      win            <= '1;
      fmask          <= '0;
      ones           <= '0;
      bit_cnt        <= '0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_Data        <= '0;
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_FCSerr      <= 1'b0;
      Rx_ByteCount   <= '0;
    end else begin
      win            <= {Rx, win[7:1]};
      fmask          <= {1'b0, fmask[7:1] | {7{flag_match | abort_match}}};
      Rx_FlagDetect  <= flag_match;
      Rx_AbortDetect <= abort_match;
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;

      if (state == IDLE || exit_flag || !exit_bit) ones <= '0;
      else if (ones != 3'd7)                       ones <= ones + 3'd1;

      if (kept) begin
        Rx_Data <= {exit_bit, Rx_Data[7:1]};
        bit_cnt <= frame_start ? 3'd1 : bit_cnt + 3'd1;
      end

      if (frame_start) begin
        Rx_AbortSignal <= 1'b0;
        Rx_FrameError  <= 1'b0;
        Rx_Overflow    <= 1'b0;
        Rx_FCSerr      <= 1'b0;
        Rx_ByteCount   <= '0;
      end

      if (byte_done) begin
        if (Rx_ByteCount >= MAX_B) begin
          Rx_Overflow <= 1'b1;
        end else begin
          Rx_WrBuff    <= 1'b1;
          Rx_ByteCount <= Rx_ByteCount + 8'd1;
        end
      end

      if (frame_abort) begin
        Rx_EoF         <= 1'b1;
        Rx_AbortSignal <= 1'b1;
      end else if (frame_end) begin
        Rx_EoF        <= 1'b1;
        Rx_FrameError <= (bit_cnt != 3'd0) || (Rx_ByteCount < MIN_B);
        Rx_FCSerr     <= fcs_bad;
      end
    end
  end
endmodule

// File: tb/tb_hdlc_rx_channel.sv
// Randomized self-checking bench for hdlc_rx_channel: frames are bit-stuffed by a transmit model
// and received bytes / end-of-frame status are compared with expectations from the frame contents.
module tb_hdlc_rx_channel;
  localparam int MAXB = 4;
  localparam int MINB = 2;

  logic       Clk = 1'b0, Rst = 1'b0, Rx = 1'b1, RxEN = 1'b0, Rx_FCSen = 1'b0;
  logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_WrBuff, Rx_EoF;
  logic       Rx_AbortSignal, Rx_FrameError, Rx_Overflow, Rx_FCSerr;
  logic [7:0] Rx_Data, Rx_ByteCount;

  int checks = 0, errors = 0, cyc = 0, clash = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  hdlc_rx_channel #(.MAX_FRAME_BYTES(MAXB), .MIN_FRAME_BYTES(MINB)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .Rx_FCSen(Rx_FCSen),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_Data(Rx_Data), .Rx_WrBuff(Rx_WrBuff), .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_FrameError(Rx_FrameError), .Rx_Overflow(Rx_Overflow), .Rx_FCSerr(Rx_FCSerr),
    .Rx_ByteCount(Rx_ByteCount)
  );

  typedef struct {
    bit err, abt, ovf, fcs;
    int cnt;
    bit after_flag, after_abort;
  } eof_t;

  logic [7:0] got[$];
  eof_t       eofs[$];
  int         flag_cyc[$], abort_cyc[$];
  bit         valid_seen, prev_flag, prev_abort;

  always @(negedge Clk) begin
    if (Rx_WrBuff) got.push_back(Rx_Data);
    if (Rx_FlagDetect) flag_cyc.push_back(cyc);
    if (Rx_AbortDetect) abort_cyc.push_back(cyc);
    if (Rx_ValidFrame) valid_seen = 1'b1;
    if (Rx_WrBuff && Rx_EoF) clash++;
    if (Rx_EoF) eofs.push_back('{Rx_FrameError, Rx_AbortSignal, Rx_Overflow, Rx_FCSerr,
                                 int'(Rx_ByteCount), prev_flag, prev_abort});
    prev_flag  = Rx_FlagDetect;
    prev_abort = Rx_AbortDetect;
  end

  // transmit model: flags reset the ones run; a 0 is inserted after every five data ones
  bit txq[$];
  int tx_ones = 0;

  task automatic push_flag();
    for (int i = 0; i < 8; i++) txq.push_back(i != 0 && i != 7);
    tx_ones = 0;
  endtask

  task automatic push_data(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      txq.push_back(v[i]);
      if (v[i]) begin
        tx_ones++;
        if (tx_ones == 5) begin
          txq.push_back(1'b0);
          tx_ones = 0;
        end
      end else tx_ones = 0;
    end
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) txq.push_back(1'b1);
  endtask

  task automatic send();
    while (txq.size() > 0) begin
      @(posedge Clk);
      #1 Rx = txq.pop_front();
    end
  endtask

  task automatic clear_mon();
    got.delete(); eofs.delete(); flag_cyc.delete(); abort_cyc.delete();
    valid_seen = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d[$], input int extra, input logic [7:0] xv);
    clear_mon();
    push_flag();
    foreach (d[i]) push_data(d[i], 8);
    push_data(xv, extra);
    push_flag();
    push_ones(20);
    send();
  endtask

`ifdef HDLC_RX_FCS_CHECK_EN
  // remainder of M(x)*x^16 divided by x^16+x^15+x^2+1, message bits in line order
  function automatic logic [15:0] fcs_of(input logic [7:0] d[$]);
    bit m[$];
    logic [16:0] r = '0;
    foreach (d[i]) for (int b = 0; b < 8; b++) m.push_back(d[i][b]);
    for (int i = 0; i < 16; i++) m.push_back(1'b0);
    foreach (m[i]) begin
      r = {r[15:0], m[i]};
      if (r[16]) r = r ^ 17'h18005;
    end
    return r[15:0];
  endfunction
`endif

  task automatic test_reset();
    Rst = 1'b0; RxEN = 1'b1; Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
         Rx_Overflow, Rx_FCSerr, Rx_Data, Rx_ByteCount} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs, required all 0");
    end
    Rst = 1'b1;
  endtask

  task automatic test_flag();
    int t;
    clear_mon();
    push_ones(20); send();
    push_flag(); send();
    t = cyc;
    push_ones(12); send();
    checks++;
    if (flag_cyc.size() != 1) begin
      errors++; $display("FAIL flag_pulse_count got %0d required 1", flag_cyc.size());
    end else begin
      checks++;
      if (flag_cyc[0] != t + 2) begin
        errors++; $display("FAIL flag_latency got cycle %0d required %0d", flag_cyc[0], t + 2);
      end
    end
    checks++;
    if (valid_seen !== 1'b0) begin errors++; $display("FAIL flag_valid got 1 required 0"); end
  endtask

  task automatic test_basic(input logic [7:0] a, input logic [7:0] b, input string nm);
    logic [7:0] d[$];
    d = '{a, b};
    run_frame(d, 0, 8'h00);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL %s_wrbuff_count got %0d required 2", nm, got.size());
    end else begin
      checks++;
      if ({got[0], got[1]} !== {a, b}) begin
        errors++; $display("FAIL %s_data got %h %h required %h %h", nm, got[0], got[1], a, b);
      end
    end
    checks++;
    if (eofs.size() != 1) begin
      errors++; $display("FAIL %s_eof_count got %0d required 1", nm, eofs.size());
    end else begin
      checks++;
      if ({eofs[0].err, eofs[0].abt, eofs[0].ovf, eofs[0].after_flag} !== 4'b0001 || eofs[0].cnt != 2) begin
        errors++; $display("FAIL %s_status got err=%0b abt=%0b ovf=%0b after_flag=%0b cnt=%0d required 0 0 0 1 2",
                           nm, eofs[0].err, eofs[0].abt, eofs[0].ovf, eofs[0].after_flag, eofs[0].cnt);
      end
    end
  endtask

  task automatic test_frame_error(input int n, input int extra, input string nm);
    logic [7:0] d[$];
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    run_frame(d, extra, 8'h05);
    checks++;
    if (got.size() != n) begin errors++; $display("FAIL %s_wrbuff_count got %0d required %0d", nm, got.size(), n); end
    checks++;
    if (eofs.size() != 1) begin
      errors++; $display("FAIL %s_eof_count got %0d required 1", nm, eofs.size());
    end else begin
      checks++;
      if (eofs[0].err !== 1'b1) begin errors++; $display("FAIL %s_frame_error got 0 required 1", nm); end
    end
  endtask

  task automatic test_abort();
    int t;
    clear_mon();
    push_flag(); push_data(8'h11, 8); send();
    txq.push_back(1'b0); push_ones(7); send();
    t = cyc;
    push_ones(12); send();
    checks++;
    if (abort_cyc.size() != 1 || abort_cyc[0] != t + 2) begin
      errors++; $display("FAIL abort_detect got %0d pulses (first at %0d) required 1 at %0d",
                         abort_cyc.size(), abort_cyc.size() > 0 ? abort_cyc[0] : -1, t + 2);
    end
    checks++;
    if (eofs.size() != 1) begin
      errors++; $display("FAIL abort_eof_count got %0d required 1", eofs.size());
    end else begin
      checks++;
      if ({eofs[0].abt, eofs[0].after_abort} !== 2'b11) begin
        errors++; $display("FAIL abort_status got abt=%0b after_abort=%0b required 1 1", eofs[0].abt, eofs[0].after_abort);
      end
    end
    checks++;
    if (got.size() != 1 || got[0] !== 8'h11) begin
      errors++; $display("FAIL abort_data got %0d bytes required one byte 11", got.size());
    end
    checks++;
    if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL abort_idle got valid=%b required 0", Rx_ValidFrame); end
  endtask

  task automatic test_overflow();
    logic [7:0] d[$];
    int bad = 0;
    for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
    run_frame(d, 0, 8'h00);
    checks++;
    if (got.size() != MAXB) begin
      errors++; $display("FAIL ovf_wrbuff_count got %0d required %0d", got.size(), MAXB);
    end else begin
      foreach (got[i]) if (got[i] !== d[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ovf_data got %0d wrong bytes required 0", bad); end
    end
    checks++;
    if (eofs.size() != 1) begin
      errors++; $display("FAIL ovf_eof_count got %0d required 1", eofs.size());
    end else begin
      checks++;
      if ({eofs[0].ovf, eofs[0].err} !== 2'b10 || eofs[0].cnt != MAXB) begin
        errors++; $display("FAIL ovf_status got ovf=%0b err=%0b cnt=%0d required 1 0 %0d",
                           eofs[0].ovf, eofs[0].err, eofs[0].cnt, MAXB);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$], b[$], exp_q[$];
    int bad = 0;
    for (int i = 0; i < 3; i++) a.push_back(8'($urandom));
    for (int i = 0; i < 2; i++) b.push_back(8'($urandom));
    exp_q = {a, b};
    clear_mon();
    push_flag();
    foreach (a[i]) push_data(a[i], 8);
    push_flag();
    foreach (b[i]) push_data(b[i], 8);
    push_flag(); push_ones(20); send();
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL b2b_wrbuff_count got %0d required 5", got.size());
    end else begin
      foreach (got[i]) if (got[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_data got %0d wrong bytes required 0", bad); end
    end
    checks++;
    if (eofs.size() != 2) begin
      errors++; $display("FAIL b2b_eof_count got %0d required 2", eofs.size());
    end else begin
      checks++;
      if (eofs[0].cnt != 3 || eofs[1].cnt != 2 || eofs[0].err || eofs[1].err) begin
        errors++; $display("FAIL b2b_status got cnt %0d/%0d err %0b/%0b required 3/2 0/0",
                           eofs[0].cnt, eofs[1].cnt, eofs[0].err, eofs[1].err);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [7:0] d[$];
      int n, extra, ecnt, bad;
      bit eerr, eovf;
      n     = $urandom_range(1, 6);
      extra = ($urandom % 3 == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < n; i++) d.push_back(($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
      run_frame(d, extra, 8'($urandom));
      ecnt = (n > MAXB) ? MAXB : n;
      eerr = (extra != 0) || (ecnt < MINB);
      eovf = (n > MAXB);
      bad  = 0;
      checks++;
      if (got.size() != ecnt) begin
        errors++; $display("FAIL rand_wrbuff_count it=%0d got %0d required %0d", it, got.size(), ecnt);
      end else begin
        foreach (got[i]) if (got[i] !== d[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_data it=%0d got %0d wrong bytes required 0", it, bad); end
      end
      checks++;
      if (eofs.size() != 1) begin
        errors++; $display("FAIL rand_eof_count it=%0d got %0d required 1", it, eofs.size());
      end else begin
        checks++;
        if ({eofs[0].err, eofs[0].abt, eofs[0].ovf, eofs[0].fcs, eofs[0].after_flag} !== {eerr, 1'b0, eovf, 1'b0, 1'b1}
            || eofs[0].cnt != ecnt) begin
          errors++; $display("FAIL rand_status it=%0d got err=%0b abt=%0b ovf=%0b fcs=%0b af=%0b cnt=%0d required %0b 0 %0b 0 1 %0d",
                             it, eofs[0].err, eofs[0].abt, eofs[0].ovf, eofs[0].fcs, eofs[0].after_flag,
                             eofs[0].cnt, eerr, eovf, ecnt);
        end
      end
    end
  endtask

  task automatic test_fcs();
    logic [7:0] d[$];
    bit exp_bad;
    Rx_FCSen = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      d.delete();
      d.push_back(8'($urandom));
      d.push_back(8'($urandom));
`ifdef HDLC_RX_FCS_CHECK_EN
      begin
        logic [15:0] f;
        logic [7:0] b0, b1;
        f = fcs_of(d);
        for (int i = 0; i < 8; i++) begin
          b0[i] = f[15 - i];
          b1[i] = f[7 - i];
        end
        if (pass == 1) b1 = b1 ^ 8'h10;
        d.push_back(b0);
        d.push_back(b1);
      end
      exp_bad = (pass == 1);
`else
      d.push_back(8'($urandom));
      exp_bad = 1'b0;
`endif
      run_frame(d, 0, 8'h00);
      checks++;
      if (eofs.size() != 1 || eofs[0].fcs !== exp_bad || eofs[0].err !== 1'b0) begin
        errors++; $display("FAIL fcs_pass%0d got %0d eofs fcserr=%0b required 1 eof fcserr=%0b",
                           pass, eofs.size(), eofs.size() > 0 ? eofs[0].fcs : 1'b0, exp_bad);
      end
    end
    Rx_FCSen = 1'b0;
  endtask

  task automatic test_reset_midframe();
    push_flag(); push_data(8'h11, 8); push_data(8'h03, 4); send();
    checks++;
    if (Rx_ValidFrame !== 1'b1) begin errors++; $display("FAIL midframe_valid got %b required 1", Rx_ValidFrame); end
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
         Rx_Overflow, Rx_FCSerr, Rx_Data, Rx_ByteCount} !== 25'd0) begin
      errors++; $display("FAIL midframe_reset got nonzero outputs, required all 0");
    end
    Rx = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_flag();
    test_basic(8'hA5, 8'h3C, "basic");
    test_basic(8'hFF, 8'h00, "stuff");
    test_frame_error(1, 3, "ferr_short_misaligned");
    test_frame_error(2, 3, "ferr_misaligned");
    test_frame_error(1, 0, "ferr_short");
    test_abort();
    test_overflow();
    test_back_to_back();
    test_random();
    test_fcs();
    test_reset_midframe();
    checks++;
    if (clash != 0) begin errors++; $display("FAIL wrbuff_eof_overlap got %0d cycles required 0", clash); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
